// File: rtl/time_set_ctrl.sv
// Button-driven editor for clock hour/minute and reminder hour, committed to the timekeeper via set codes.
// Optional SET_TIMEOUT_EN: abandons an edit session after TIMEOUT_CYCLES without a press.
module time_set_ctrl #(
  parameter int unsigned DEB_CYCLES     = 2000000,
  parameter int unsigned COMMIT_CYCLES  = 2000000,
`ifdef SET_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
`endif
  parameter int unsigned REMIND_DEFAULT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       btn_mode_raw,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_confirm_raw,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [1:0] set_all_times,
  output logic [5:0] btn_time_set,
  output logic [5:0] btn_min_set,
  output logic [1:0] edit_field,
  output logic       set_done
);

  localparam int unsigned NB  = 4;
  localparam int unsigned TW  = 6;
  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned CCW = $clog2(COMMIT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    EDIT_HOUR,
    EDIT_MIN,
    EDIT_REMIND,
    COMMIT_TIME,
    COMMIT_REMIND
  } state_e;

  // ---------------- debounce ----------------
  logic [NB-1:0]          raw_c;
  logic [NB-1:0]          sync1_q, sync2_q;
  logic [NB-1:0]          stable_q, stable_d;
  logic [NB-1:0]          press_q, press_d;
  logic [NB-1:0][DCW-1:0] deb_cnt_q, deb_cnt_d;

  assign raw_c = {btn_confirm_raw, btn_down_raw, btn_up_raw, btn_mode_raw};

  // Counter runs only while the synchronised level disagrees with the accepted level
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    deb_cnt_d = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= raw_c;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  logic mode_p, up_p, down_p, confirm_p;
  assign mode_p    = press_q[0];
  assign up_p      = press_q[1];
  assign down_p    = press_q[2];
  assign confirm_p = press_q[3];

  // ---------------- edit FSM ----------------
  state_e          state_q, state_d;
  logic [TW-1:0]   hour_q, hour_d;
  logic [TW-1:0]   min_q, min_d;
  logic [TW-1:0]   remind_q, remind_d;
  logic [TW-1:0]   remind_edit_q, remind_edit_d;
  logic [CCW-1:0]  commit_cnt_q, commit_cnt_d;
  logic [1:0]      set_all_times_q, set_all_times_d;
  logic [TW-1:0]   btn_time_set_q, btn_time_set_d;
  logic [TW-1:0]   btn_min_set_q, btn_min_set_d;
  logic [1:0]      edit_field_q, edit_field_d;
  logic            set_done_q, set_done_d;
  logic            timeout_c;

  // Wrapping step within lo..hi; simultaneous up and down cancel
  function automatic logic [TW-1:0] wrap_step(input logic [TW-1:0] v, input logic [TW-1:0] lo,
                                              input logic [TW-1:0] hi, input logic up,
                                              input logic dn);
    logic [TW-1:0] r;
    r = v;
    if (up && !dn) begin
      r = (v >= hi) ? lo : v + TW'(1);
    end else if (dn && !up) begin
      r = (v <= lo || v > hi) ? hi : v - TW'(1);
    end
    return r;
  endfunction

`ifdef SET_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TOW-1:0] idle_cnt_q, idle_cnt_d;
  logic           in_edit_c;
  logic           any_press_c;

  assign in_edit_c   = state_q inside {EDIT_HOUR, EDIT_MIN, EDIT_REMIND};
  assign any_press_c = |press_q;
  assign timeout_c   = in_edit_c && !any_press_c && (idle_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_cnt_d = '0;
    if (in_edit_c && !any_press_c) begin
      idle_cnt_d = idle_cnt_q + TOW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state; confirm beats mode, mode beats up/down
  always_comb begin
    state_d       = state_q;
    hour_d        = hour_q;
    min_d         = min_q;
    remind_d      = remind_q;
    remind_edit_d = remind_edit_q;
    commit_cnt_d  = '0;
    set_done_d    = 1'b0;
    if (!power_on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (mode_p) begin
            hour_d  = cur_hour;
            min_d   = cur_minute;
            state_d = EDIT_HOUR;
          end
        end
        EDIT_HOUR: begin
          if (confirm_p)      state_d = COMMIT_TIME;
          else if (mode_p)    state_d = EDIT_MIN;
          else if (timeout_c) state_d = IDLE;
          else hour_d = wrap_step(hour_q, TW'(0), TW'(23), up_p, down_p);
        end
        EDIT_MIN: begin
          if (confirm_p) begin
            state_d = COMMIT_TIME;
          end else if (mode_p) begin
            state_d       = EDIT_REMIND;
            remind_edit_d = remind_q;
          end else if (timeout_c) begin
            state_d = IDLE;
          end else begin
            min_d = wrap_step(min_q, TW'(0), TW'(59), up_p, down_p);
          end
        end
        EDIT_REMIND: begin
          if (confirm_p) begin
            state_d  = COMMIT_REMIND;
            remind_d = remind_edit_q;
          end else if (mode_p || timeout_c) begin
            state_d = IDLE;
          end else begin
            remind_edit_d = wrap_step(remind_edit_q, TW'(1), TW'(23), up_p, down_p);
          end
        end
        COMMIT_TIME, COMMIT_REMIND: begin
          if (commit_cnt_q == CCW'(COMMIT_CYCLES - 1)) begin
            state_d    = IDLE;
            set_done_d = 1'b1;
          end else begin
            commit_cnt_d = commit_cnt_q + CCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs derived from the next state so they register alongside it
  always_comb begin
    set_all_times_d = 2'b00;
    edit_field_d    = 2'b00;
    btn_time_set_d  = '0;
    btn_min_set_d   = '0;
    case (state_d)
      EDIT_HOUR: begin
        edit_field_d   = 2'b01;
        btn_time_set_d = hour_d;
        btn_min_set_d  = min_d;
      end
      EDIT_MIN: begin
        edit_field_d   = 2'b10;
        btn_time_set_d = hour_d;
        btn_min_set_d  = min_d;
      end
      EDIT_REMIND: begin
        edit_field_d   = 2'b11;
        btn_time_set_d = hour_d;
        btn_min_set_d  = min_d;
      end
      COMMIT_TIME: begin
        set_all_times_d = 2'b01;
        btn_time_set_d  = hour_d;
        btn_min_set_d   = min_d;
      end
      COMMIT_REMIND: begin
        set_all_times_d = 2'b10;
        btn_time_set_d  = remind_d;
        btn_min_set_d   = min_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      hour_q          <= '0;
      min_q           <= '0;
      remind_q        <= TW'(REMIND_DEFAULT);
      remind_edit_q   <= TW'(REMIND_DEFAULT);
      commit_cnt_q    <= '0;
      set_all_times_q <= 2'b00;
      btn_time_set_q  <= '0;
      btn_min_set_q   <= '0;
      edit_field_q    <= 2'b00;
      set_done_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      hour_q          <= hour_d;
      min_q           <= min_d;
      remind_q        <= remind_d;
      remind_edit_q   <= remind_edit_d;
      commit_cnt_q    <= commit_cnt_d;
      set_all_times_q <= set_all_times_d;
      btn_time_set_q  <= btn_time_set_d;
      btn_min_set_q   <= btn_min_set_d;
      edit_field_q    <= edit_field_d;
      set_done_q      <= set_done_d;
    end
  end

  assign set_all_times = set_all_times_q;
  assign btn_time_set  = btn_time_set_q;
  assign btn_min_set   = btn_min_set_q;
  assign edit_field    = edit_field_q;
  assign set_done      = set_done_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: every output change must match the next queued
// expectation, including the cycle at which it happens.
module tb_time_set_ctrl;

  localparam int DEB    = 4;
  localparam int COMMIT = 8;
  localparam int LAT    = DEB + 3;  // raw edge -> pulse (DEB+2) -> registered output (+1)
  localparam int HOLD   = 8;
  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_CONF = 4'b1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic       btn_mode_raw, btn_up_raw, btn_down_raw, btn_confirm_raw;
  logic [5:0] cur_hour, cur_minute;
  logic [1:0] set_all_times;
  logic [5:0] btn_time_set, btn_min_set;
  logic [1:0] edit_field;
  logic       set_done;

  time_set_ctrl #(
    .DEB_CYCLES(DEB),
    .COMMIT_CYCLES(COMMIT),
`ifdef SET_TIMEOUT_EN
    .TIMEOUT_CYCLES(50),
`endif
    .REMIND_DEFAULT(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .power_on(power_on),
    .btn_mode_raw(btn_mode_raw),
    .btn_up_raw(btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .btn_confirm_raw(btn_confirm_raw),
    .cur_hour(cur_hour),
    .cur_minute(cur_minute),
    .set_all_times(set_all_times),
    .btn_time_set(btn_time_set),
    .btn_min_set(btn_min_set),
    .edit_field(edit_field),
    .set_done(set_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] sat;
    logic [5:0] bts;
    logic [5:0] bms;
    logic [1:0] ef;
    logic       done;
    int         at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_seen   = 0;
  logic        started  = 1'b0;
  logic [16:0] prev_o;
  logic [16:0] cur_o;

  assign cur_o = {set_all_times, btn_time_set, btn_min_set, edit_field, set_done};

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_out(input logic [1:0] sat, input logic [5:0] bts, input logic [5:0] bms,
                            input logic [1:0] ef, input logic done, input int at);
    exp_t e;
    e.sat = sat; e.bts = bts; e.bms = bms; e.ef = ef; e.done = done; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic drive_raw(input logic [3:0] m);
    {btn_confirm_raw, btn_down_raw, btn_up_raw, btn_mode_raw} = m;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_btn(input logic [3:0] m, output int c);
    @(posedge clk);
    #1;
    drive_raw(m);
    c = cyc;
  endtask

  task automatic release_btn(input int c);
    at_cycle(c + HOLD);
    drive_raw(4'b0000);
    at_cycle(c + 2 * HOLD);
  endtask

  task automatic tap(input logic [3:0] m, input logic [1:0] sat, input logic [5:0] bts,
                     input logic [5:0] bms, input logic [1:0] ef);
    int c;
    push_btn(m, c);
    expect_out(sat, bts, bms, ef, 1'b0, c + LAT);
    release_btn(c);
  endtask

  task automatic tap_quiet(input logic [3:0] m);
    int c;
    push_btn(m, c);
    release_btn(c);
  endtask

  task automatic tap_commit(input logic [3:0] m, input logic [1:0] sat, input logic [5:0] bts,
                            input logic [5:0] bms);
    int c;
    push_btn(m, c);
    expect_out(sat, bts, bms, 2'b00, 1'b0, c + LAT);
    expect_out(2'b00, 6'd0, 6'd0, 2'b00, 1'b1, c + LAT + COMMIT);
    expect_out(2'b00, 6'd0, 6'd0, 2'b00, 1'b0, c + LAT + COMMIT + 1);
    release_btn(c);
  endtask

  // Monitor: any output change pops one expectation
  initial begin
    exp_t        e;
    logic [16:0] eo;
    wait (started);
    forever begin
      @(negedge clk);
      if (cur_o !== prev_o) begin
        n_checks++;
        n_seen++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_change#%0d: got sat=%b time=%0d min=%0d field=%b done=%b @cyc %0d, required no change",
                   n_seen, cur_o[16:15], cur_o[14:9], cur_o[8:3], cur_o[2:1], cur_o[0], cyc);
        end else begin
          e  = exp_q.pop_front();
          eo = {e.sat, e.bts, e.bms, e.ef, e.done};
          if (cur_o !== eo || cyc != e.at) begin
            n_fail++;
            $display("FAIL out_change#%0d: got sat=%b time=%0d min=%0d field=%b done=%b @cyc %0d, required sat=%b time=%0d min=%0d field=%b done=%b @cyc %0d",
                     n_seen, cur_o[16:15], cur_o[14:9], cur_o[8:3], cur_o[2:1], cur_o[0], cyc,
                     e.sat, e.bts, e.bms, e.ef, e.done, e.at);
          end
        end
        prev_o = cur_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    reset      = 1'b0;
    power_on   = 1'b1;
    drive_raw(4'b0000);
    cur_hour   = 6'd23;
    cur_minute = 6'd59;
    repeat (3) @(posedge clk);
    #1;
    check("rst_set_all_times", int'(set_all_times), 0);
    check("rst_btn_time_set", int'(btn_time_set), 0);
    check("rst_btn_min_set", int'(btn_min_set), 0);
    check("rst_edit_field", int'(edit_field), 0);
    check("rst_set_done", int'(set_done), 0);
    prev_o  = cur_o;
    started = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    // Hour/minute edit with wraps in both directions, then commit 00:00
    tap(B_MODE, 2'b00, 6'd23, 6'd59, 2'b01);
    tap(B_UP,   2'b00, 6'd0,  6'd59, 2'b01);
    tap(B_DOWN, 2'b00, 6'd23, 6'd59, 2'b01);
    tap(B_UP,   2'b00, 6'd0,  6'd59, 2'b01);
    tap(B_MODE, 2'b00, 6'd0,  6'd59, 2'b10);
    tap(B_UP,   2'b00, 6'd0,  6'd0,  2'b10);
    tap(B_DOWN, 2'b00, 6'd0,  6'd59, 2'b10);
    tap(B_UP,   2'b00, 6'd0,  6'd0,  2'b10);
    tap_commit(B_CONF, 2'b01, 6'd0, 6'd0);

    // Bounced up press yields one step, timed from the last raw edge
    cur_hour   = 6'd5;
    cur_minute = 6'd30;
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    @(posedge clk); #1; drive_raw(B_UP);
    @(posedge clk); #1; drive_raw(4'b0000);
    @(posedge clk); #1; drive_raw(B_UP);
    c = cyc;
    expect_out(2'b00, 6'd6, 6'd30, 2'b01, 1'b0, c + LAT);
    release_btn(c);
    tap(B_DOWN, 2'b00, 6'd5, 6'd30, 2'b01);

    // Up+down cancel; confirm beats up
    tap_quiet(B_UP | B_DOWN);
    check("updown_cancel_hour", int'(btn_time_set), 5);
    tap_commit(B_UP | B_CONF, 2'b01, 6'd5, 6'd30);

    // Power loss in the third commit cycle aborts without set_done
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    push_btn(B_CONF, c);
    expect_out(2'b01, 6'd5, 6'd30, 2'b00, 1'b0, c + LAT);
    expect_out(2'b00, 6'd0, 6'd0, 2'b00, 1'b0, c + LAT + 3);
    at_cycle(c + LAT + 2);
    power_on = 1'b0;
    release_btn(c);
    tap_quiet(B_MODE);
    power_on = 1'b1;
    check("power_off_field", int'(edit_field), 0);

    // Asynchronous reset in the middle of an edit
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    tap(B_UP,   2'b00, 6'd6, 6'd30, 2'b01);
    @(posedge clk);
    #2;
    expect_out(2'b00, 6'd0, 6'd0, 2'b00, 1'b0, cyc);
    reset = 1'b0;
    #1;
    check("async_set_all_times", int'(set_all_times), 0);
    check("async_btn_time_set", int'(btn_time_set), 0);
    check("async_btn_min_set", int'(btn_min_set), 0);
    check("async_edit_field", int'(edit_field), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reminder from default 10, up x14 wraps 23 -> 1
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b10);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b11);
    for (int i = 0; i < 14; i++) tap_quiet(B_UP);
    tap_commit(B_CONF, 2'b10, 6'd1, 6'd30);

    // Abort from reminder field leaves stored reminder at 1
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b10);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b11);
    tap_quiet(B_DOWN);
    tap(B_MODE, 2'b00, 6'd0, 6'd0, 2'b00);

    // Mode beats up; reminder 1 down wraps to 23; confirm beats mode
    tap(B_MODE,        2'b00, 6'd5, 6'd30, 2'b01);
    tap(B_MODE | B_UP, 2'b00, 6'd5, 6'd30, 2'b10);
    tap(B_MODE,        2'b00, 6'd5, 6'd30, 2'b11);
    tap_quiet(B_DOWN);
    tap_commit(B_CONF | B_MODE, 2'b10, 6'd23, 6'd30);

`ifdef SET_TIMEOUT_EN
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    push_btn(B_MODE, c);
    expect_out(2'b00, 6'd5, 6'd30, 2'b10, 1'b0, c + LAT);
    expect_out(2'b00, 6'd0, 6'd0, 2'b00, 1'b0, c + LAT + 50);
    release_btn(c);
    at_cycle(c + LAT + 60);
`else
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b01);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b10);
    at_cycle(cyc + 60);
    tap(B_MODE, 2'b00, 6'd5, 6'd30, 2'b11);
    tap(B_MODE, 2'b00, 6'd0, 6'd0,  2'b00);
`endif

    at_cycle(cyc + 20);
    check("pending_expectations", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
